golden_nonce_uart_tx: RTL and testbench

//  Host-facing transmit end of the nonce result path: takes golden-nonce results from

---
 rtl/golden_nonce_uart_tx.sv | 171 +++++++++++++++++
 tb/tb_golden_nonce_uart_tx.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/golden_nonce_uart_tx.sv
// Golden-nonce return path: queues nonces from the hashing core and sends each one
// over an 8N1 UART line as four bytes, most significant byte first.
module golden_nonce_uart_tx #(
    parameter int CLK_FREQUENCY   = 50_000_000,
    parameter int BAUD_RATE       = 115200,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [31:0]                golden_nonce,
    input  logic                       golden_nonce_valid,
    output logic                       uart_tx,
    output logic                       busy,
    output logic                       overflow,
    output logic [FIFO_DEPTH_LOG2:0]   fifo_count
);

    // state | meaning
    // IDLE  | line high, waiting for a queued nonce
    // START | start bit (low) of the current byte
    // DATA  | eight data bits, LSB first
    // STOP  | stop bit (high); next byte or back to IDLE
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam int DIV    = CLK_FREQUENCY / BAUD_RATE;
    localparam int BAUD_W = $clog2(DIV);
    localparam int DEPTH  = 1 << FIFO_DEPTH_LOG2;
    localparam int CNT_W  = FIFO_DEPTH_LOG2 + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(DIV - 1);
    localparam logic [CNT_W-1:0]  COUNT_FULL = CNT_W'(DEPTH);

    logic [31:0]                mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
    logic                       full;
    logic                       push_ok;
    logic                       pop;

    state_t             state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [1:0]         byte_q, byte_d;
    logic [31:0]        shift_q, shift_d;
    logic [7:0]         tx_byte_q, tx_byte_d;
    logic               line_d;
    logic               baud_end;

    assign full     = (fifo_count == COUNT_FULL);
    // A push into a full FIFO still fits when the head leaves on the same edge.
    assign push_ok  = golden_nonce_valid && (!full || pop);
    assign baud_end = (baud_q == BAUD_LAST);
    assign busy     = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= golden_nonce;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + FIFO_DEPTH_LOG2'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_DEPTH_LOG2'(1);
            end
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (golden_nonce_valid && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            shift_q   <= '0;
            tx_byte_q <= '0;
            uart_tx   <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            shift_q   <= shift_d;
            tx_byte_q <= tx_byte_d;
            uart_tx   <= line_d;
        end
    end

    // The line register follows the current state, so uart_tx lags the state by one cycle.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        shift_d   = shift_q;
        tx_byte_d = tx_byte_q;
        pop       = 1'b0;
        line_d    = 1'b1;
        case (state_q)
            IDLE: begin
                if (fifo_count != '0) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr];
                    byte_d  = 2'd0;
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                line_d = 1'b0;
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                    case (byte_q)
                        2'd0:    tx_byte_d = shift_q[31:24];
                        2'd1:    tx_byte_d = shift_q[23:16];
                        2'd2:    tx_byte_d = shift_q[15:8];
                        default: tx_byte_d = shift_q[7:0];
                    endcase
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                line_d = tx_byte_q[bit_q];
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                line_d = 1'b1;
                if (baud_end) begin
                    baud_d = '0;
                    if (byte_q == 2'd3) begin
                        state_d = IDLE;
                    end else begin
                        byte_d  = byte_q + 2'd1;
                        state_d = START;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_golden_nonce_uart_tx.sv
// Bench for golden_nonce_uart_tx: directed vectors and corner sequences plus random
// traffic, all checked cycle by cycle against a queue-and-timer model of the line.
module tb_golden_nonce_uart_tx;

    localparam int DIV   = 16;
    localparam int FRAME = 40 * DIV;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] golden_nonce = '0;
    logic        golden_nonce_valid = 1'b0;
    logic        uart_tx;
    logic        busy;
    logic        overflow;
    logic [2:0]  fifo_count;

    always #5 clk = ~clk;

    golden_nonce_uart_tx #(
        .CLK_FREQUENCY  (1600),
        .BAUD_RATE      (100),
        .FIFO_DEPTH_LOG2(2)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .golden_nonce      (golden_nonce),
        .golden_nonce_valid(golden_nonce_valid),
        .uart_tx           (uart_tx),
        .busy              (busy),
        .overflow          (overflow),
        .fifo_count        (fifo_count)
    );

    int checks = 0;
    int failures = 0;

    logic       line_hist[$];
    logic       busy_hist[$];
    logic [7:0] dec_bytes[$];
    int         dec_starts[$];
    int         peak;

    // Reference model: queued nonces, the nonce on the line, and cycles left in its frame.
    logic [31:0] m_q[$];
    logic [31:0] m_cur;
    int          m_busy;
    logic        m_ovf;
    logic        m_line;

    typedef struct {
        logic [31:0] nonce;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [7:0]  b3;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_cur  = '0;
        m_busy = 0;
        m_ovf  = 1'b0;
        m_line = 1'b1;
    endtask

    task automatic model_step(input logic v, input logic [31:0] d);
        int   pos, bitn, slot, byte_n;
        logic pop_now;
        if (m_busy == 0) begin
            m_line = 1'b1;
        end else begin
            pos    = FRAME - m_busy;
            bitn   = pos / DIV;
            byte_n = bitn / 10;
            slot   = bitn % 10;
            if (slot == 0)      m_line = 1'b0;
            else if (slot == 9) m_line = 1'b1;
            else                m_line = m_cur[(3 - byte_n) * 8 + slot - 1];
        end
        pop_now = (m_busy == 0) && (m_q.size() != 0);
        if (v) begin
            if (m_q.size() < DEPTH || pop_now) m_q.push_back(d);
            else m_ovf = 1'b1;
        end
        if (pop_now) begin
            m_cur  = m_q.pop_front();
            m_busy = FRAME;
        end else if (m_busy != 0) begin
            m_busy--;
        end
    endtask

    // Called at a falling edge; drives inputs, steps across one rising edge, checks at the next fall.
    task automatic cycle(input logic v, input logic [31:0] d);
        golden_nonce_valid = v;
        golden_nonce       = d;
        @(posedge clk);
        model_step(v, d);
        @(negedge clk);
        golden_nonce_valid = 1'b0;
        check("line",       64'(uart_tx),    64'(m_line));
        check("busy",       64'(busy),       64'(m_busy != 0));
        check("overflow",   64'(overflow),   64'(m_ovf));
        check("fifo_count", 64'(fifo_count), 64'(m_q.size()));
        line_hist.push_back(uart_tx);
        busy_hist.push_back(busy);
        if (int'(fifo_count) > peak) peak = int'(fifo_count);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, $urandom);
    endtask

    task automatic clear_hist();
        line_hist.delete();
        busy_hist.delete();
        peak = 0;
    endtask

    task automatic do_reset(input int n);
        golden_nonce_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("rst_line",       64'(uart_tx),    64'(1));
        check("rst_busy",       64'(busy),       64'(0));
        check("rst_overflow",   64'(overflow),   64'(0));
        check("rst_fifo_count", 64'(fifo_count), 64'(0));
        model_reset();
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_hold_line", 64'(uart_tx), 64'(1));
        end
        reset_n = 1'b1;
    endtask

    // Recovers bytes from the recorded line by sampling each bit at its centre.
    task automatic decode_hist();
        int i;
        logic [7:0] b;
        dec_bytes.delete();
        dec_starts.delete();
        i = 0;
        while (i + 10 * DIV <= line_hist.size()) begin
            if (line_hist[i] == 1'b0) begin
                for (int k = 0; k < 8; k++) b[k] = line_hist[i + DIV / 2 + DIV * (k + 1)];
                check("start_bit", 64'(line_hist[i + DIV / 2]),           64'(0));
                check("stop_bit",  64'(line_hist[i + DIV / 2 + 9 * DIV]), 64'(1));
                dec_bytes.push_back(b);
                dec_starts.push_back(i);
                i += 9 * DIV + DIV / 2 + 1;
            end else begin
                i++;
            end
        end
    endtask

    task automatic check_stream(input string name, input logic [31:0] exp_n[], input int cnt);
        check({name, "_nbytes"}, 64'(dec_bytes.size()), 64'(cnt * 4));
        if (dec_bytes.size() == cnt * 4) begin
            for (int j = 0; j < cnt * 4; j++)
                check(name, 64'(dec_bytes[j]), 64'(8'(exp_n[j / 4] >> (24 - 8 * (j % 4)))));
        end
    endtask

    initial begin
        logic [31:0] t2[] = '{32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4,
                              32'hD1D2D3D4, 32'hE1E2E3E4, 32'hF1F2F3F4};
        logic [31:0] t3[] = '{32'hDEADBEEF, 32'h00000000};
        logic [31:0] t4[] = '{32'h0BADF00D};
        logic [31:0] t5[] = '{32'hC0FFEE01, 32'h01020304, 32'h05060708,
                              32'h090A0B0C, 32'h0D0E0F10, 32'hA1B2C3D4};
        int bc;
        int zeros;

        vecs[0] = '{32'h12345678, 8'h12, 8'h34, 8'h56, 8'h78};
        vecs[1] = '{32'hDEADBEEF, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        vecs[2] = '{32'h00000000, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[3] = '{32'hFFFFFFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        vecs[4] = '{32'hA5C30F81, 8'hA5, 8'hC3, 8'h0F, 8'h81};

        model_reset();
        @(negedge clk);
        do_reset(3);

        // single nonces: byte order, start latency, busy length
        for (int n = 0; n < 5; n++) begin
            clear_hist();
            cycle(1'b1, vecs[n].nonce);
            idle(FRAME + 20);
            decode_hist();
            check("vec_nbytes", 64'(dec_bytes.size()), 64'(4));
            if (dec_bytes.size() == 4) begin
                check("vec_b0", 64'(dec_bytes[0]), 64'(vecs[n].b0));
                check("vec_b1", 64'(dec_bytes[1]), 64'(vecs[n].b1));
                check("vec_b2", 64'(dec_bytes[2]), 64'(vecs[n].b2));
                check("vec_b3", 64'(dec_bytes[3]), 64'(vecs[n].b3));
                check("vec_fall_latency", 64'(dec_starts[0]), 64'(2));
            end
            bc = 0;
            foreach (busy_hist[k]) if (busy_hist[k]) bc++;
            check("vec_busy_cycles", 64'(bc), 64'(FRAME));
        end

        // two back-to-back nonces, the second all zero
        clear_hist();
        cycle(1'b1, t3[0]);
        cycle(1'b1, t3[1]);
        idle(2 * FRAME + 20);
        decode_hist();
        check_stream("b2b_byte", t3, 2);
        if (dec_starts.size() >= 5)
            check("b2b_gap", 64'(dec_starts[4] - dec_starts[0]), 64'(FRAME + 1));

        // six consecutive strobes: the sixth is dropped
        clear_hist();
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, t2[k]);
            if (k == 4) check("ovf_before_drop", 64'(overflow), 64'(0));
            if (k == 5) check("ovf_after_drop",  64'(overflow), 64'(1));
        end
        check("peak_fifo_count", 64'(peak), 64'(4));
        idle(5 * FRAME + 50);
        decode_hist();
        check_stream("burst_byte", t2, 5);
        check("ovf_sticky", 64'(overflow), 64'(1));

        // reset during the data bits of the third byte
        clear_hist();
        cycle(1'b1, 32'hFFFF00FF);
        cycle(1'b1, 32'h11111111);
        cycle(1'b1, 32'h22222222);
        idle(383);
        check("pre_reset_line",  64'(uart_tx),    64'(0));
        check("pre_reset_count", 64'(fifo_count), 64'(2));
        check("pre_reset_ovf",   64'(overflow),   64'(1));
        do_reset(3);
        clear_hist();
        cycle(1'b1, t4[0]);
        idle(FRAME + 20);
        decode_hist();
        check_stream("post_reset_byte", t4, 1);

        // push while full on the very edge the head is popped
        clear_hist();
        for (int k = 0; k < 5; k++) cycle(1'b1, t5[k]);
        check("full_count", 64'(fifo_count), 64'(4));
        idle(637);
        check("gap_busy",  64'(busy),       64'(0));
        check("gap_count", 64'(fifo_count), 64'(4));
        cycle(1'b1, t5[5]);
        check("pushpop_count", 64'(fifo_count), 64'(4));
        check("pushpop_ovf",   64'(overflow),   64'(0));
        idle(5 * FRAME + 50);
        decode_hist();
        check_stream("pushpop_byte", t5, 6);

        // data changing with no strobe
        clear_hist();
        idle(50);
        zeros = 0;
        foreach (line_hist[k]) if (!line_hist[k]) zeros++;
        check("nostrobe_count", 64'(fifo_count), 64'(0));
        check("nostrobe_line",  64'(zeros),      64'(0));

        // random traffic: sparse, then dense enough to overflow
        do_reset(2);
        clear_hist();
        repeat (6000) cycle($urandom_range(0, 999) < 3, $urandom);
        repeat (3000) cycle($urandom_range(0, 999) < 60, $urandom);
        idle(5 * FRAME + 50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
